// File: rtl/muldiv_unit_if.sv
// Start/ready request bus between the execute stage and the iterative
// RISC-V M-extension multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide
// on sign-stripped magnitudes, one bit per cycle, sign fix-up at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rstn,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_negQ;
  logic              r_negR;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_isDiv;
  logic              w_sgnA;
  logic              w_sgnB;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic              w_divZero;
  logic              w_ovf;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mulNext;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_divNext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_isDiv   = r_op[2];
  assign w_sgnA    = w_isDiv ? ~r_op[0] : (r_op[1:0] != 2'b11);
  assign w_sgnB    = w_isDiv ? ~r_op[0] : ~r_op[1];
  assign w_negA    = w_sgnA & r_a[XLEN-1];
  assign w_negB    = w_sgnB & r_b[XLEN-1];
  assign w_magA    = w_negA ? (~r_a + XLEN'(1)) : r_a;
  assign w_magB    = w_negB ? (~r_b + XLEN'(1)) : r_b;
  assign w_divZero = (r_b == '0);
  assign w_ovf     = ~r_op[0] & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == {XLEN{1'b1}});

  // Multiply: product register holds {partial sum, remaining multiplier bits}.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mulNext = {w_sum, r_acc[XLEN-1:1]};

  // Divide: register holds {partial remainder, dividend bits shifting into quotient}.
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_trial - {1'b0, r_b};
  assign w_ge      = (w_trial >= {1'b0, r_b});
  assign w_divNext = {(w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  assign w_prod = r_negQ ? (~r_acc + (2*XLEN)'(1)) : r_acc;
  assign w_quo  = r_negQ ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_rem  = r_negR ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:          w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:  w_final = w_quo;
      default:         w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_op    <= bus.funct3;
              r_a     <= bus.rs1;
              r_b     <= bus.rs2;
              r_state <= PREP;
            end
          end
          PREP: begin
            r_a     <= w_magA;
            r_b     <= w_magB;
            r_negQ  <= w_negA ^ w_negB;
            r_negR  <= w_negA;
            r_acc   <= {{XLEN{1'b0}}, (w_isDiv ? w_magA : w_magB)};
            r_cnt   <= CW'(XLEN);
            r_state <= CALC;
            // Special divides leave {remainder, quotient} final and skip CALC.
            if (w_isDiv && w_divZero) begin
              r_acc   <= {r_a, {XLEN{1'b1}}};
              r_negQ  <= 1'b0;
              r_negR  <= 1'b0;
              r_state <= FIN;
            end else if (w_isDiv && w_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, r_a};
              r_negQ  <= 1'b0;
              r_negR  <= 1'b0;
              r_state <= FIN;
            end
          end
          CALC: begin
            r_acc <= w_isDiv ? w_divNext : w_mulNext;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= FIN;
            end
          end
          FIN: begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ready  = (r_state == IDLE);
  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule
